// File: rtl/binary_encoder_16x4_if.sv
// rtl/binary_encoder_16x4_if.sv - request-vector / code handshake bundle for the 16-to-4 encoder
interface binary_encoder_16x4_if;
  logic [15:0] bcode;
  logic        load;
  logic        ready;
  logic [3:0]  a;
  logic        valid;
  logic        busy;
  logic        done;
  logic [4:0]  remaining;

  modport master (
    output bcode, load, ready,
    input  a, valid, busy, done, remaining
  );

  modport slave (
    input  bcode, load, ready,
    output a, valid, busy, done, remaining
  );
endinterface

// File: rtl/binary_encoder_16x4.sv
// rtl/binary_encoder_16x4.sv - sequential 16-to-4 encoder, drains set bits highest index first
module binary_encoder_16x4 (
  input  logic                 clk,
  input  logic                 rst_n,
  binary_encoder_16x4_if.slave bus
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [3:0]  a_q, a_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  remaining_q, remaining_d;

  function automatic logic [3:0] msb_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [4:0] pop_count(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    return cnt;
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          if (bus.bcode != '0) begin
            pending_d = bus.bcode;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
            state_d   = SERVE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SERVE: begin
        if (valid_q && bus.ready) begin
          pending_d = pending_q & ~(16'h0001 << a_q);
          if (pending_d == '0) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Once drained, a keeps the last code rather than collapsing to 0.
    a_d         = (pending_d != '0) ? msb_index(pending_d) : a_q;
    remaining_d = pop_count(pending_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      a_q         <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      a_q         <= a_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = remaining_q;

endmodule

// File: doc/binary_encoder_16x4.md
# binary_encoder_16x4

Sequential 16-to-4 binary encoder: the return path for the 4x16 binary decoder. It captures a 16-bit request vector and emits the 4-bit index of every set bit, one per accepted transfer, highest index first, over a valid/ready handshake. Downstream it feeds 4-bit address or select logic; upstream it sits behind any block that produces decoded one-hot or multi-hot vectors.

## Interface
- no parameters; widths are fixed at 16 inputs and 4 outputs
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- bcode  input  16  request vector, sampled only on load
- load  input  1  capture strobe, honoured only in IDLE
- ready  input  1  consumer accepts the current code
- a  output  4  encoded index of the current highest pending bit (registered)
- valid  output  1  a is valid (registered)
- busy  output  1  high while in SERVE (registered)
- done  output  1  one-cycle pulse when a captured vector is fully drained, or was empty (registered)
- remaining  output  5  number of pending set bits, range 0..16 (registered)

## Operation
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Internal state: pending[15:0], plus an FSM with two states, IDLE and SERVE.
- Reset (async, rst_n=0):
  - pending, a, valid, busy, done and remaining all go to 0.
  - The FSM goes to IDLE.
- IDLE, load=1 and bcode≠0:
  - pending <= bcode.
  - a <= index of the highest set bit.
  - valid <= 1, busy <= 1.
  - remaining <= popcount(bcode).
  - Go to SERVE.
- IDLE, load=1 and bcode=0:
  - done <= 1 for one cycle.
  - valid and busy stay 0, and a stays at its old value.
  - Stay in IDLE.
- SERVE, valid && ready:
  - Clear bit a in pending.
  - Decrement remaining.
  - If other bits remain: a <= highest remaining index, valid stays 1.
  - If none remain: valid <= 0, busy <= 0, done <= 1, go to IDLE. a holds the last code.
- SERVE, ready=0: a, valid and remaining hold. There is no timeout.
- load during SERVE is ignored. pending is not modified.
- Priority rule: a higher bit index always wins, so bcode[15] is served first.
- Arithmetic: remaining is 5 bits so that 16 can be represented.
- The index and popcount logic is combinational on the next value of pending. All outputs are registered.

## Timing
- Latency: with load high at edge N, valid and the first code are visible after edge N.
- Throughput: with ready held high, one code per cycle. A vector with k set bits drains in k cycles after the load edge.
- Handshake rules:
  - A transfer occurs on the edge where valid && ready.
  - Once asserted, valid is never dropped without a transfer.
  - a is stable while valid && !ready.
- done:
  - It is asserted in the cycle after the edge that accepted the last code, and lasts exactly one cycle.
  - busy falls on the same edge that raises done.
- Back-to-back operation: load may be asserted in the cycle where done=1, since the FSM is already in IDLE. The new capture then occurs on that edge.
- Reset mid-SERVE: all outputs drop to 0 immediately, without waiting for a clock. The captured vector is discarded, and operation resumes in IDLE after rst_n deasserts.
- Boundary case, bcode=16'hFFFF: remaining=16, and the codes 15 down to 0 are emitted over 16 transfers.

## Test plan
- Reset check: hold rst_n=0 with random inputs.
  - Required: a=0, valid=0, busy=0, done=0, remaining=0.
  - Release rst_n and check that there is no spurious valid.
- Exhaustive single-bit sweep (decoder dual): for i=0..15, load bcode=1<<i with ready=1.
  - Required: a=i with valid for exactly one cycle.
  - Required: remaining goes 1 then 0, and done pulses once.
  - Also chain the decoder output through this block and check a matches the decoder input.
- Multi-bit order: load 16'h8421 with ready=1.
  - Required: a=15,10,5,0 on consecutive cycles.
  - Required: remaining=4,3,2,1.
  - Required: done in the cycle after code 0 is accepted.
- Backpressure and ignored load: load 16'h0030, then hold ready=0 for 3 cycles while pulsing load with 16'hFFFF.
  - Required: a=5 is held with valid=1 and remaining=2 throughout.
  - Required: after ready=1, the codes are 5 then 4. The 16'hFFFF load has no effect.
- Empty vector and full vector:
  - load 0 -> done pulses one cycle, valid never rises.
  - load 16'hFFFF -> 16 codes from 15 down to 0, remaining starts at 16.
- Async reset mid-drain: load 16'h00FF, accept 2 codes, then drop rst_n between clock edges.
  - Required: all outputs are 0 before the next edge.
  - After release, a new load of 16'h0002 yields a=1.
